vram_arbiter: RTL

- Shares one single-port synchronous character/pattern VRAM between two requesters:
  - the video fetch path, which has hard-real-time, fixed-latency, absolute priority;
  - a CPU/bus port, which uses a req/ack handshake.
- Sits between the video controller's VRAM address/data pins and the VRAM macro.
- Tags each issued slot so returning read data is steered to the correct requester.

---
 rtl/vram_arb_pkg.sv | 6 +
 rtl/vram_arbiter_if.sv | 26 ++
 rtl/vram_arb_tagpipe.sv | 28 ++
 rtl/vram_arbiter.sv | 63 ++++++
 4 files changed

// File: rtl/vram_arb_pkg.sv
// vram_arb_pkg: shared CPU FSM states, slot tags and read latency for the VRAM arbiter.
package vram_arb_pkg;
    typedef enum logic [1:0] {IDLE, ISSUED, RDWAIT, ACK} cpu_state_t;
    typedef enum logic [1:0] {NONE, VID, CPU_RD, CPU_WR} slot_t;
    localparam int RD_LAT = 2;
endpackage

// File: rtl/vram_arbiter_if.sv
// vram_arbiter_if: video, CPU and VRAM-side signal bundle of the VRAM arbiter.
interface vram_arbiter_if #(parameter int ADDR_W = 12, parameter int DATA_W = 8);
    logic              vid_req;
    logic [ADDR_W-1:0] vid_adr;
    logic [DATA_W-1:0] vid_dat;
    logic              vid_dat_vld;
    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_adr;
    logic [DATA_W-1:0] cpu_wdat;
    logic [DATA_W-1:0] cpu_rdat;
    logic              cpu_ack;
    logic [ADDR_W-1:0] ram_adr;
    logic              ram_we;
    logic [DATA_W-1:0] ram_wdat;
    logic [DATA_W-1:0] ram_rdat;
    logic [15:0]       stat_conflicts;
    modport slave (
        input  vid_req, vid_adr, cpu_req, cpu_we, cpu_adr, cpu_wdat, ram_rdat,
        output vid_dat, vid_dat_vld, cpu_rdat, cpu_ack, ram_adr, ram_we, ram_wdat, stat_conflicts
    );
    modport master (
        output vid_req, vid_adr, cpu_req, cpu_we, cpu_adr, cpu_wdat, ram_rdat,
        input  vid_dat, vid_dat_vld, cpu_rdat, cpu_ack, ram_adr, ram_we, ram_wdat, stat_conflicts
    );
endinterface

// File: rtl/vram_arb_tagpipe.sv
// vram_arb_tagpipe: slot tag shift register that steers returning VRAM data to video or CPU.
module vram_arb_tagpipe import vram_arb_pkg::*; #(parameter int DATA_W = 8) (
    input  logic              pixel_clock,
    input  logic              reset,
    input  slot_t             tag_in,
    input  logic [DATA_W-1:0] ram_rdat,
    output slot_t             tag_issued,
    output logic [DATA_W-1:0] vid_dat,
    output logic              vid_dat_vld,
    output logic [DATA_W-1:0] cpu_rdat
);
    slot_t tags [RD_LAT];
    always_ff @(posedge pixel_clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < RD_LAT; i++) tags[i] <= NONE;
            vid_dat     <= '0;
            vid_dat_vld <= 1'b0;
            cpu_rdat    <= '0;
        end else begin
            tags[0] <= tag_in;
            for (int i = 1; i < RD_LAT; i++) tags[i] <= tags[i-1];
            vid_dat_vld <= tags[RD_LAT-1] == VID;
            if (tags[RD_LAT-1] == VID) vid_dat <= ram_rdat;
            if (tags[RD_LAT-1] == CPU_RD) cpu_rdat <= ram_rdat;
        end
    end
    assign tag_issued = tags[0];
endmodule

// File: rtl/vram_arbiter.sv
// vram_arbiter: shares one single-port VRAM between fixed-latency video fetch and a req/ack CPU port.
// Define VRAM_ARB_STATS_EN to enable the stat_conflicts video/CPU collision counter.
module vram_arbiter import vram_arb_pkg::*; #(parameter int ADDR_W = 12, parameter int DATA_W = 8) (
    input logic         pixel_clock,
    input logic         reset,
    vram_arbiter_if.slave bus
);
    cpu_state_t        state, state_nx;
    slot_t             slot, tag_issued;
    logic              cpu_go;
    logic [ADDR_W-1:0] adr_q;
    logic [DATA_W-1:0] wdat_q;
    logic              we_q;
    assign cpu_go = state == IDLE && bus.cpu_req && !bus.vid_req;
    assign slot   = bus.vid_req ? VID : !cpu_go ? NONE : bus.cpu_we ? CPU_WR : CPU_RD;
    // the issued tag, not cpu_we, decides the branch so an early cpu_req drop still completes
    always_comb
        state_nx = state == IDLE   ? (cpu_go ? ISSUED : IDLE) :
                   state == ISSUED ? (tag_issued == CPU_WR ? ACK : RDWAIT) :
                   state == RDWAIT ? ACK : IDLE;
    always_ff @(posedge pixel_clock or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nx;
    end
    always_ff @(posedge pixel_clock or negedge reset) begin
        if (!reset) begin
            adr_q  <= '0;
            wdat_q <= '0;
            we_q   <= 1'b0;
        end else begin
            we_q <= cpu_go && bus.cpu_we;
            if (bus.vid_req) adr_q <= bus.vid_adr;
            else if (cpu_go) begin
                adr_q  <= bus.cpu_adr;
                wdat_q <= bus.cpu_wdat;
            end
        end
    end
    assign bus.ram_adr  = adr_q;
    assign bus.ram_wdat = wdat_q;
    assign bus.ram_we   = we_q;
    assign bus.cpu_ack  = state == ACK;
    vram_arb_tagpipe #(.DATA_W(DATA_W)) u_tagpipe (
        .pixel_clock(pixel_clock),
        .reset(reset),
        .tag_in(slot),
        .ram_rdat(bus.ram_rdat),
        .tag_issued(tag_issued),
        .vid_dat(bus.vid_dat),
        .vid_dat_vld(bus.vid_dat_vld),
        .cpu_rdat(bus.cpu_rdat)
    );
`ifdef VRAM_ARB_STATS_EN
    logic [15:0] conflicts;
    always_ff @(posedge pixel_clock or negedge reset) begin
        if (!reset) conflicts <= '0;
        else if (state == IDLE && bus.cpu_req && bus.vid_req && conflicts != 16'hFFFF) conflicts <= conflicts + 16'd1;
    end
    assign bus.stat_conflicts = conflicts;
`else
    assign bus.stat_conflicts = '0;
`endif
endmodule
